// File: rtl/muldiv_pkg.sv
// Shared types and widths for the muldiv engine issuer.
package muldiv_pkg;

  localparam int OP1_W = 32;
  localparam int OP2_W = 64;
  localparam int RES_W = 64;
  localparam int REQ_W = OP1_W + OP2_W + 1;

  // muordi encodings understood by the engine
  localparam logic MUL = 1'b1;
  localparam logic DIV = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    ERST,
    SETUP,
    START,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic             mul;
    logic [OP1_W-1:0] op1;
    logic [OP2_W-1:0] op2;
  } req_t;

endpackage

// File: rtl/muldiv_issuer_if.sv
// Request/response bus between datapath control (master) and the issuer (slave).
interface muldiv_issuer_if;
  import muldiv_pkg::*;

  // Handshakes: a beat transfers on a rising clock edge where valid && ready are
  // both high; the sender holds valid and its payload stable until that edge.
  logic             req_valid;
  logic             req_ready;
  logic [OP1_W-1:0] req_op1;
  logic [OP2_W-1:0] req_op2;
  logic             req_mul;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [RES_W-1:0] rsp_result;
  logic             rsp_mul;
  logic             rsp_timeout;

  modport master (
    output req_valid, req_op1, req_op2, req_mul, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_mul, rsp_timeout
  );

  modport slave (
    input  req_valid, req_op1, req_op2, req_mul, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_mul, rsp_timeout
  );

endinterface

// File: rtl/muldiv_req_fifo.sv
// Synchronous first-word-fall-through FIFO holding pending muldiv requests.
module muldiv_req_fifo #(
  parameter int W     = 97,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign dout  = mem[rd_ptr];

  // A pop frees the head slot first, so a full FIFO can still take a push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/muldiv_issuer.sv
// Queues muldiv requests and sequences them one at a time onto the engine,
// returning the engine result (or a timeout) on a held response port.
module muldiv_issuer
  import muldiv_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 128,
  parameter int CW         = 8
) (
  input  logic             clock,
  input  logic             reset,
  muldiv_issuer_if.slave   bus,
  output logic             busy,
  output logic             eng_reset,
  output logic             eng_start,
  output logic [OP1_W-1:0] eng_opera1,
  output logic [OP2_W-1:0] eng_opera2,
  output logic             eng_muordi,
  input  logic             eng_valid,
  input  logic [RES_W-1:0] eng_result,
  output state_t           dbg_state
);

  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  state_t           state;
  state_t           state_n;
  logic [CW-1:0]    cnt;
  logic [OP1_W-1:0] op1_q;
  logic [OP2_W-1:0] op2_q;
  logic             mul_q;
  logic [RES_W-1:0] res_q;
  logic             tmo_q;
  logic             tmo_rst_q;
  logic             pop;
  logic             tmo_hit;

  logic             fifo_full;
  logic             fifo_empty;
  logic [REQ_W-1:0] fifo_din;
  logic [REQ_W-1:0] fifo_dout;
  req_t             head;

  assign fifo_din = {bus.req_mul, bus.req_op1, bus.req_op2};
  assign head     = fifo_dout;

  muldiv_req_fifo #(
    .W     (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (bus.req_valid && !fifo_full),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    tmo_hit = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = ERST;
        end
      end
      ERST:  state_n = SETUP;
      SETUP: state_n = START;
      START: state_n = WAIT;
      WAIT: begin
        // A result arriving on the last counted cycle beats the timeout.
        if (eng_valid) begin
          state_n = RESP;
        end else if (cnt == TMO_LAST) begin
          tmo_hit = 1'b1;
          state_n = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_n = ERST;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt       <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      mul_q     <= MUL;
      res_q     <= '0;
      tmo_q     <= 1'b0;
      tmo_rst_q <= 1'b0;
    end else begin
      tmo_rst_q <= tmo_hit;
      if (pop) begin
        op1_q <= head.op1;
        op2_q <= head.op2;
        mul_q <= head.mul;
      end
      if (state == START)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt + CW'(1);
      if (state == WAIT) begin
        if (eng_valid) begin
          res_q <= eng_result;
          tmo_q <= 1'b0;
        end else if (tmo_hit) begin
          res_q <= '0;
          tmo_q <= 1'b1;
        end
      end
    end
  end

  // The extra reset pulse after a timeout clears a hung engine before reuse.
  assign eng_reset  = reset || (state == ERST) || tmo_rst_q;
  assign eng_start  = (state == START);
  assign eng_opera1 = op1_q;
  assign eng_opera2 = op2_q;
  assign eng_muordi = mul_q;

  assign bus.req_ready   = !fifo_full;
  assign bus.rsp_valid   = (state == RESP);
  assign bus.rsp_result  = res_q;
  assign bus.rsp_mul     = mul_q;
  assign bus.rsp_timeout = tmo_q;

  assign busy      = (state != IDLE) || !fifo_empty;
  assign dbg_state = state;

endmodule

// File: tb/tb_muldiv_issuer.sv
// Directed scoreboard bench for muldiv_issuer with a behavioural engine model.
module tb_muldiv_issuer;
  import muldiv_pkg::*;

  localparam int TIMEOUT = 128;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        busy;
  logic        eng_reset;
  logic        eng_start;
  logic [31:0] eng_opera1;
  logic [63:0] eng_opera2;
  logic        eng_muordi;
  logic        eng_valid  = 1'b0;
  logic [63:0] eng_result = '0;
  state_t      dbg_state;

  muldiv_issuer_if bus();

  muldiv_issuer #(
    .FIFO_DEPTH (4),
    .TIMEOUT    (TIMEOUT),
    .CW         (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .busy       (busy),
    .eng_reset  (eng_reset),
    .eng_start  (eng_start),
    .eng_opera1 (eng_opera1),
    .eng_opera2 (eng_opera2),
    .eng_muordi (eng_muordi),
    .eng_valid  (eng_valid),
    .eng_result (eng_result),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [65:0] exp_q[$];  // {timeout, mul, result}
  logic [96:0] iss_q[$];  // {mul, op1, op2}
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s", name);
  endtask

  // ---------------- engine model ----------------
  int   eng_lat  = 2;
  bit   eng_hang = 1'b0;

  function automatic logic [63:0] eng_calc(input logic [31:0] a, input logic [63:0] b,
                                           input logic m);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed(b);
    if (m)            return 64'(sa * sb);
    else if (a == '0) return '1;
    else              return 64'(sb / sa);
  endfunction

  initial begin
    bit          pend;
    int          ecnt;
    logic [63:0] eres;
    pend = 1'b0;
    ecnt = 0;
    eres = '0;
    forever begin
      @(negedge clock);
      eng_valid = 1'b0;
      if (eng_reset === 1'b1) begin
        pend = 1'b0;
      end else if (eng_start === 1'b1) begin
        pend = 1'b1;
        ecnt = eng_lat;
        eres = eng_calc(eng_opera1, eng_opera2, eng_muordi);
      end else if (pend && !eng_hang) begin
        if (ecnt == 0) begin
          eng_valid  = 1'b1;
          eng_result = eres;
          pend       = 1'b0;
        end else begin
          ecnt--;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic        rst_h1;
    logic        rst_h2;
    logic        start_h1;
    logic        rv_h1;
    int          cyc;
    int          start_cyc;
    logic [65:0] e;
    logic [96:0] iss;
    rst_h1 = 1'b0; rst_h2 = 1'b0; start_h1 = 1'b0; rv_h1 = 1'b0;
    cyc = 0; start_cyc = 0;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset === 1'b0) begin
        if (eng_start === 1'b1) begin
          chk("start_after_erst_setup", {62'd0, rst_h2, rst_h1}, 64'd2);
          chk("start_one_cycle", {63'd0, start_h1}, 64'd0);
          if (iss_q.size() == 0) begin
            fail("unexpected_eng_start");
          end else begin
            iss = iss_q.pop_front();
            chk("eng_muordi", {63'd0, eng_muordi}, {63'd0, iss[96]});
            chk("eng_opera1", {32'd0, eng_opera1}, {32'd0, iss[95:64]});
            chk("eng_opera2", eng_opera2, iss[63:0]);
          end
          start_cyc = cyc;
        end
        if (bus.rsp_valid === 1'b1 && rv_h1 !== 1'b1 && bus.rsp_timeout === 1'b1) begin
          chk("timeout_latency", 64'(cyc - start_cyc), 64'(TIMEOUT + 1));
          chk("timeout_eng_reset", {63'd0, eng_reset}, 64'd1);
        end
        if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            fail("unexpected_rsp");
          end else begin
            e = exp_q.pop_front();
            chk("rsp_result", bus.rsp_result, e[63:0]);
            chk("rsp_mul", {63'd0, bus.rsp_mul}, {63'd0, e[64]});
            chk("rsp_timeout", {63'd0, bus.rsp_timeout}, {63'd0, e[65]});
          end
        end
      end
      rst_h2   = rst_h1;
      rst_h1   = eng_reset;
      start_h1 = eng_start;
      rv_h1    = bus.rsp_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [31:0] op1, input logic [63:0] op2, input logic m,
                      input logic [63:0] res, input logic tmo);
    bit acc;
    int n;
    bus.req_valid = 1'b1;
    bus.req_op1   = op1;
    bus.req_op2   = op2;
    bus.req_mul   = m;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 400) begin
      @(negedge clock);
      acc = bus.req_ready;
      @(posedge clock);
      n++;
    end
    if (acc) begin
      exp_q.push_back({tmo, m, res});
      iss_q.push_back({m, op1, op2});
    end else begin
      fail("push_not_accepted");
    end
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    @(negedge clock);
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s: drain timed out, %0d responses outstanding", name, exp_q.size());
    end
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_eng_reset"},   {63'd0, eng_reset}, 64'd1);
    chk({tag, "_eng_muordi"},  {63'd0, eng_muordi}, 64'd1);
    chk({tag, "_eng_start"},   {63'd0, eng_start}, 64'd0);
    chk({tag, "_rsp_valid"},   {63'd0, bus.rsp_valid}, 64'd0);
    chk({tag, "_rsp_timeout"}, {63'd0, bus.rsp_timeout}, 64'd0);
    chk({tag, "_rsp_result"},  bus.rsp_result, 64'd0);
    chk({tag, "_eng_opera1"},  {32'd0, eng_opera1}, 64'd0);
    chk({tag, "_eng_opera2"},  eng_opera2, 64'd0);
    chk({tag, "_busy"},        {63'd0, busy}, 64'd0);
    chk({tag, "_req_ready"},   {63'd0, bus.req_ready}, 64'd1);
    chk({tag, "_state"},       {61'd0, dbg_state}, {61'd0, IDLE});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int          n;
    logic [63:0] snap_res;
    bus.req_valid = 1'b0;
    bus.req_op1   = '0;
    bus.req_op2   = '0;
    bus.req_mul   = 1'b0;
    bus.rsp_ready = 1'b1;

    repeat (3) @(negedge clock);
    chk_reset_values("por");
    reset = 1'b0;
    @(posedge clock);
    #1;

    // single and signed multiply, one divide
    push(32'h64, 64'hA, MUL, 64'h3E8, 1'b0);
    wait_drain("single_mul");
    push(32'hFFFF_FFFA, 64'hD, MUL, 64'hFFFF_FFFF_FFFF_FFB2, 1'b0);
    push(32'd7, 64'd100, DIV, 64'd14, 1'b0);
    wait_drain("signed_mul_div");

    // five requests into a four-entry FIFO behind a slow engine
    eng_lat = 10;
    push(32'd2, 64'd3, MUL, 64'd6, 1'b0);
    push(32'h10, 64'h10, MUL, 64'h100, 1'b0);
    push(32'hFFFF_FFFF, 64'd5, MUL, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0);
    push(32'd4, 64'h40, DIV, 64'h10, 1'b0);
    push(32'h1000, 64'h1000, MUL, 64'h100_0000, 1'b0);
    @(negedge clock);
    chk("req_ready_when_full", {63'd0, bus.req_ready}, 64'd0);
    wait_drain("queueing");
    eng_lat = 2;

    // response backpressure with a second request waiting
    bus.rsp_ready = 1'b0;
    push(32'd3, 64'd7, MUL, 64'h15, 1'b0);
    push(32'd2, 64'h20, MUL, 64'h40, 1'b0);
    n = 0;
    @(negedge clock);
    while (bus.rsp_valid !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("bp_rsp_valid_seen", {63'd0, bus.rsp_valid}, 64'd1);
    snap_res = bus.rsp_result;
    chk("bp_first_result", snap_res, 64'h15);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("bp_valid_held", {63'd0, bus.rsp_valid}, 64'd1);
      chk("bp_result_held", bus.rsp_result, snap_res);
      chk("bp_no_start", {63'd0, eng_start}, 64'd0);
    end
    @(posedge clock);
    #1 bus.rsp_ready = 1'b1;
    wait_drain("backpressure");

    // engine never answers, then a normal request
    eng_hang = 1'b1;
    push(32'd5, 64'd5, MUL, 64'd0, 1'b1);
    wait_drain("timeout");
    eng_hang = 1'b0;
    push(32'd9, 64'd9, MUL, 64'h51, 1'b0);
    wait_drain("after_timeout");

    // reset while waiting on the engine, with one more request queued
    eng_hang = 1'b1;
    push(32'd1, 64'd1, MUL, 64'd1, 1'b0);
    push(32'd2, 64'd2, MUL, 64'd4, 1'b0);
    n = 0;
    @(negedge clock);
    while (dbg_state != WAIT && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("reached_wait", {61'd0, dbg_state}, {61'd0, WAIT});
    reset = 1'b1;
    exp_q.delete();
    iss_q.delete();
    @(negedge clock);
    chk_reset_values("mid_reset");
    reset    = 1'b0;
    eng_hang = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("no_stale_rsp", {63'd0, bus.rsp_valid}, 64'd0);
      chk("idle_after_reset", {63'd0, busy}, 64'd0);
    end
    @(posedge clock);
    #1;
    push(32'h11, 64'd2, MUL, 64'h22, 1'b0);
    wait_drain("after_reset");

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
